// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion helpers and pointer mode constants
package gray_pkg;

  // Widest pointer the helpers handle; callers zero-extend in and truncate out.
  localparam int GRAY_MAX_W = 32;

  localparam int MODE_WR = 0;
  localparam int MODE_RD = 1;

  // Zero-extension keeps the low bits exact for any narrower pointer.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the low result intact.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for a peer-domain Gray pointer
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous Gray value through the flop chain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// rtl/gray_fifo_ptr.sv - Gray-coded async FIFO pointer with level and full/empty flags
module gray_fifo_ptr
  import gray_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int ALMOST_TH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic [ADDR_W:0]   peer_gray,
  output logic [ADDR_W:0]   ptr_gray,
  output logic [ADDR_W:0]   ptr_bin,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   level,
  output logic              flag,
  output logic              almost,
  output logic              err_ovr
);

  localparam int PW = ADDR_W + 1;
  localparam int D  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH      = PW'(D);
  localparam logic [ADDR_W:0] TH_EMPTY   = PW'(ALMOST_TH);
  localparam logic [ADDR_W:0] TH_FULL    = PW'(D - ALMOST_TH);
  localparam logic            RST_FLAG   = (MODE == MODE_RD);
  localparam logic            RST_ALMOST = (MODE == MODE_RD) ? 1'b1 : (ALMOST_TH >= D);

  logic [ADDR_W:0] ptr_bin_q, ptr_bin_d;
  logic [ADDR_W:0] ptr_gray_q, ptr_gray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            flag_q, flag_d;
  logic            almost_q, almost_d;
  logic            err_ovr_q, err_ovr_d;
  logic [ADDR_W:0] psync_gray;
  logic [ADDR_W:0] psync_bin;
  logic            accept;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (peer_gray),
    .q_o     (psync_gray)
  );

  // Next pointer, occupancy and flags; a request while full/empty is dropped
  // against the registered flag, so a just-moved peer never rescues it.
  always_comb begin
    accept     = inc & ~flag_q;
    ptr_bin_d  = accept ? ptr_bin_q + PW'(1) : ptr_bin_q;
    ptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(ptr_bin_d)));
    psync_bin  = PW'(gray2bin(GRAY_MAX_W'(psync_gray)));
    if (MODE == MODE_WR) begin
      level_d  = ptr_bin_d - psync_bin;
      flag_d   = (level_d == DEPTH);
      almost_d = (level_d >= TH_FULL);
    end else begin
      level_d  = psync_bin - ptr_bin_d;
      flag_d   = (level_d == '0);
      almost_d = (level_d <= TH_EMPTY);
    end
    err_ovr_d = inc & flag_q;
  end

  // Register pointer, Gray copy, occupancy and flags on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      level_q    <= '0;
      flag_q     <= RST_FLAG;
      almost_q   <= RST_ALMOST;
      err_ovr_q  <= 1'b0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      level_q    <= level_d;
      flag_q     <= flag_d;
      almost_q   <= almost_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  assign ptr_bin  = ptr_bin_q;
  assign ptr_gray = ptr_gray_q;
  assign addr     = ptr_bin_q[ADDR_W-1:0];
  assign level    = level_q;
  assign flag     = flag_q;
  assign almost   = almost_q;
  assign err_ovr  = err_ovr_q;

`ifndef SYNTHESIS
  a_gray_step: assert property (@(posedge clk) disable iff (reset)
    $countones(ptr_gray_q ^ $past(ptr_gray_q)) <= 1)
    else $fatal(1, "gray_fifo_ptr: ptr_gray moved more than one bit");

  a_sync_step: assert property (@(posedge clk) disable iff (reset)
    $countones(psync_gray ^ $past(psync_gray)) <= 1)
    else $fatal(1, "gray_fifo_ptr: synchronised peer moved more than one bit");

  a_level_max: assert property (@(posedge clk) disable iff (reset)
    level_q <= DEPTH)
    else $fatal(1, "gray_fifo_ptr: level above depth");

  a_flag_cons: assert property (@(posedge clk) disable iff (reset)
    flag_q == ((MODE == MODE_WR) ? (level_q == DEPTH) : (level_q == '0)))
    else $fatal(1, "gray_fifo_ptr: flag disagrees with level");
`endif

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// tb/tb_gray_fifo_ptr.sv - directed bench for write-side and read-side Gray pointers
module tb_gray_fifo_ptr;

  logic       clk = 1'b0;
  logic       w_reset, w_inc;
  logic [4:0] w_peer, w_ptr_gray, w_ptr_bin, w_level;
  logic [3:0] w_addr;
  logic       w_flag, w_almost, w_err;
  logic       r_reset, r_inc;
  logic [4:0] r_peer, r_ptr_gray, r_ptr_bin, r_level;
  logic [3:0] r_addr;
  logic       r_flag, r_almost, r_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_fifo_ptr #(.ADDR_W(4), .SYNC_STAGES(2), .MODE(0), .ALMOST_TH(2)) u_wr (
    .clk(clk), .reset(w_reset), .inc(w_inc), .peer_gray(w_peer),
    .ptr_gray(w_ptr_gray), .ptr_bin(w_ptr_bin), .addr(w_addr), .level(w_level),
    .flag(w_flag), .almost(w_almost), .err_ovr(w_err)
  );

  gray_fifo_ptr #(.ADDR_W(4), .SYNC_STAGES(2), .MODE(1), .ALMOST_TH(2)) u_rd (
    .clk(clk), .reset(r_reset), .inc(r_inc), .peer_gray(r_peer),
    .ptr_gray(r_ptr_gray), .ptr_bin(r_ptr_bin), .addr(r_addr), .level(r_level),
    .flag(r_flag), .almost(r_almost), .err_ovr(r_err)
  );

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    w_reset = 1'b1; r_reset = 1'b1;
    w_inc = 1'b0;   r_inc = 1'b0;
    w_peer = '0;    r_peer = '0;
    step(); step();
    total++;
    if ({r_ptr_bin, r_ptr_gray, r_level} !== 15'd0) begin
      bad++; $display("FAIL rd_reset_ptr: got %h want 0", {r_ptr_bin, r_ptr_gray, r_level});
    end
    total++;
    if ({r_flag, r_almost, r_err} !== 3'b110) begin
      bad++; $display("FAIL rd_reset_flags: got %b want 110", {r_flag, r_almost, r_err});
    end
    total++;
    if ({w_ptr_bin, w_ptr_gray, w_level, w_flag, w_almost, w_err} !== 18'd0) begin
      bad++; $display("FAIL wr_reset: got %h want 0", {w_ptr_bin, w_ptr_gray, w_level, w_flag, w_almost, w_err});
    end
    w_reset = 1'b0; r_reset = 1'b0;
  endtask

  task automatic test_fill_overrun();
    w_inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [4:0] e;
      e = 5'(i);
      step();
      total++;
      if ({w_ptr_bin, w_level} !== {e, e}) begin
        bad++; $display("FAIL fill_ptr_level[%0d]: got %h want %h", i, {w_ptr_bin, w_level}, {e, e});
      end
      total++;
      if ({w_flag, w_almost, w_err} !== {(i == 16), (i >= 14), 1'b0}) begin
        bad++; $display("FAIL fill_flags[%0d]: got %b want %b", i, {w_flag, w_almost, w_err}, {(i == 16), (i >= 14), 1'b0});
      end
    end
    total++;
    if (w_ptr_gray !== 5'b11000) begin
      bad++; $display("FAIL full_gray: got %b want 11000", w_ptr_gray);
    end
    step();
    total++;
    if ({w_ptr_bin, w_err, w_flag} !== {5'd16, 1'b1, 1'b1}) begin
      bad++; $display("FAIL overrun: got %h want %h", {w_ptr_bin, w_err, w_flag}, {5'd16, 1'b1, 1'b1});
    end
    w_inc = 1'b0;
    step();
    total++;
    if ({w_ptr_bin, w_err} !== {5'd16, 1'b0}) begin
      bad++; $display("FAIL overrun_pulse_end: got %h want %h", {w_ptr_bin, w_err}, {5'd16, 1'b0});
    end
  endtask

  task automatic test_full_peer_race();
    w_peer = 5'b00001;
    w_inc  = 1'b1;
    step();
    total++;
    if ({w_ptr_bin, w_err, w_flag} !== {5'd16, 1'b1, 1'b1}) begin
      bad++; $display("FAIL race_drop: got %h want %h", {w_ptr_bin, w_err, w_flag}, {5'd16, 1'b1, 1'b1});
    end
    w_inc = 1'b0;
    step();
    total++;
    if ({w_level, w_flag, w_err} !== {5'd16, 1'b1, 1'b0}) begin
      bad++; $display("FAIL race_k2: got %h want %h", {w_level, w_flag, w_err}, {5'd16, 1'b1, 1'b0});
    end
    step();
    total++;
    if ({w_level, w_flag, w_almost} !== {5'd15, 1'b0, 1'b1}) begin
      bad++; $display("FAIL race_k3: got %h want %h", {w_level, w_flag, w_almost}, {5'd15, 1'b0, 1'b1});
    end
    w_inc = 1'b1;
    step();
    total++;
    if ({w_ptr_bin, w_ptr_gray, w_level, w_flag} !== {5'd17, 5'b11001, 5'd16, 1'b1}) begin
      bad++; $display("FAIL race_retry: got %h want %h", {w_ptr_bin, w_ptr_gray, w_level, w_flag}, {5'd17, 5'b11001, 5'd16, 1'b1});
    end
    w_inc = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    w_reset = 1'b1;
    w_peer  = '0;
    step();
    w_reset = 1'b0;
    prev = 5'b00000;
    for (int i = 1; i <= 33; i++) begin
      logic [4:0] e;
      e = 5'(i);
      w_inc = 1'b1;
      step();
      total++;
      if ({w_ptr_bin, w_ptr_gray, w_addr} !== {e, g5(e), e[3:0]}) begin
        bad++; $display("FAIL wrap_ptr[%0d]: got %h want %h", i, {w_ptr_bin, w_ptr_gray, w_addr}, {e, g5(e), e[3:0]});
      end
      total++;
      if ($countones(w_ptr_gray ^ prev) != 1 || w_flag !== 1'b0 || w_err !== 1'b0) begin
        bad++; $display("FAIL wrap_step[%0d]: got gray %b prev %b flag %b err %b want 1-bit step, 0, 0", i, w_ptr_gray, prev, w_flag, w_err);
      end
      if (i == 31) begin
        total++;
        if (w_ptr_gray !== 5'b10000) begin
          bad++; $display("FAIL wrap_gray31: got %b want 10000", w_ptr_gray);
        end
      end
      if (i == 32) begin
        total++;
        if ({w_ptr_bin, w_ptr_gray} !== 10'd0) begin
          bad++; $display("FAIL wrap_zero: got %h want 0", {w_ptr_bin, w_ptr_gray});
        end
      end
      prev   = w_ptr_gray;
      w_peer = g5(e - 5'd1);
    end
    w_inc = 1'b0;
  endtask

  task automatic test_empty_sync();
    r_peer = 5'b00001;
    step();
    step();
    total++;
    if ({r_flag, r_level} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL empty_k2: got %h want %h", {r_flag, r_level}, {1'b1, 5'd0});
    end
    step();
    total++;
    if ({r_flag, r_almost, r_level} !== {1'b0, 1'b1, 5'd1}) begin
      bad++; $display("FAIL empty_k3: got %h want %h", {r_flag, r_almost, r_level}, {1'b0, 1'b1, 5'd1});
    end
    r_inc = 1'b1;
    step();
    total++;
    if ({r_ptr_bin, r_ptr_gray, r_level, r_flag, r_err} !== {5'd1, 5'b00001, 5'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL empty_read: got %h want %h", {r_ptr_bin, r_ptr_gray, r_level, r_flag, r_err}, {5'd1, 5'b00001, 5'd0, 1'b1, 1'b0});
    end
    step();
    total++;
    if ({r_ptr_bin, r_flag, r_err} !== {5'd1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL underrun: got %h want %h", {r_ptr_bin, r_flag, r_err}, {5'd1, 1'b1, 1'b1});
    end
    r_inc = 1'b0;
    step();
    total++;
    if (r_err !== 1'b0) begin
      bad++; $display("FAIL underrun_pulse_end: got %b want 0", r_err);
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk);
    #3;
    w_reset = 1'b1;
    w_peer  = '0;
    #1;
    total++;
    if ({w_ptr_bin, w_ptr_gray, w_level, w_flag, w_almost, w_err} !== 18'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", {w_ptr_bin, w_ptr_gray, w_level, w_flag, w_almost, w_err});
    end
    step();
    #2;
    w_reset = 1'b0;
    w_inc   = 1'b1;
    step();
    total++;
    if ({w_ptr_bin, w_ptr_gray, w_level} !== {5'd1, 5'b00001, 5'd1}) begin
      bad++; $display("FAIL first_inc: got %h want %h", {w_ptr_bin, w_ptr_gray, w_level}, {5'd1, 5'b00001, 5'd1});
    end
    w_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_overrun();
    test_full_peer_race();
    test_wrap();
    test_empty_sync();
    test_reset_midstream();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
